icache_l2_nway: RTL and testbench

//  Parametrised N-way set-associative, read-only L2 instruction cache; next generation of the 2-way L2 I-cache.

---
 rtl/icache_l2_nway_pkg.sv | 22 ++
 rtl/icache_l2_nway_if.sv | 35 +++
 rtl/icache_l2_nway_victim_sel.sv | 22 ++
 rtl/icache_l2_nway.sv | 185 ++++++++++++++++++
 tb/tb_icache_l2_nway.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_l2_nway_pkg.sv
// Shared constants for the N-way L2 instruction cache: FSM state encoding,
// default bus widths and a constant-foldable log2 helper.
package l2_cache_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MISS   = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_LINE_W = 128;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/icache_l2_nway_if.sv
// Processor-side and memory-side bus of the L2 I-cache.
// master: the environment (L1 requester plus main memory model).
// slave:  the cache itself.
interface icache_l2_nway_if import l2_cache_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [LINE_W-1:0] proc_wdata;
    logic              proc_ready;
    logic [LINE_W-1:0] proc_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_ready, proc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_ready, proc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

endinterface

// File: rtl/icache_l2_nway_victim_sel.sv
// Victim way choice for one set: lowest-index invalid way, otherwise the
// set's round-robin pointer. Purely combinational.
module l2_victim_sel import l2_cache_pkg::*; #(
    parameter int NUM_WAY = 4,
    parameter int WAY_W   = 2
) (
    input  logic [NUM_WAY-1:0] valid_i,
    input  logic [WAY_W-1:0]   rr_ptr_i,
    output logic [WAY_W-1:0]   victim_o
);

    // Scan ways from the top down so the lowest invalid index is the last assignment
    always_comb begin
        victim_o = rr_ptr_i;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_l2_nway.sv
// N-way set-associative, read-only L2 instruction cache.
// 0-cycle hits from IDLE; misses go IDLE -> MISS (memory request) -> REFILL
// (line write plus response). Optional hit/miss counters are compiled in
// when ICACHE_L2_STATS_EN is defined.
module icache_l2_nway import l2_cache_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int NUM_SET = 32,
    parameter int NUM_WAY = 4
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    icache_l2_nway_if.slave       bus
`ifdef ICACHE_L2_STATS_EN
    ,
    output logic [31:0]           stat_hit,
    output logic [31:0]           stat_miss
`endif
);

    localparam int SET_W = clog2(NUM_SET);
    localparam int WAY_W = (NUM_WAY > 1) ? clog2(NUM_WAY) : 1;
    localparam int TAG_W = ADDR_W - SET_W;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [LINE_W-1:0] refill_buf_q, refill_buf_d;

    logic              valid_q [NUM_SET][NUM_WAY];
    logic [TAG_W-1:0]  tag_q   [NUM_SET][NUM_WAY];
    logic [LINE_W-1:0] data_q  [NUM_SET][NUM_WAY];
    logic [WAY_W-1:0]  rr_q    [NUM_SET];

    logic [SET_W-1:0]   req_set;
    logic [TAG_W-1:0]   req_tag;
    logic [SET_W-1:0]   miss_set;
    logic [TAG_W-1:0]   miss_tag;
    logic [NUM_WAY-1:0] set_valid;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_sel;
    logic [WAY_W-1:0]   rr_next;
    logic               unused_ok;

    assign req_set  = bus.proc_addr[SET_W-1:0];
    assign req_tag  = bus.proc_addr[ADDR_W-1:SET_W];
    assign miss_set = miss_addr_q[SET_W-1:0];
    assign miss_tag = miss_addr_q[ADDR_W-1:SET_W];
    assign rr_next  = (NUM_WAY == 1) ? '0 : victim_q + WAY_W'(1);

    // Writes are not supported; these inputs are deliberately unused
    assign unused_ok     = ^{bus.proc_write, bus.proc_wdata};
    assign bus.mem_write = 1'b0;
    assign bus.mem_wdata = '0;

    // Tag compare across the requested set; lowest matching way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            set_valid[w] = valid_q[req_set][w];
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    l2_victim_sel #(
        .NUM_WAY (NUM_WAY),
        .WAY_W   (WAY_W)
    ) u_victim_sel (
        .valid_i  (set_valid),
        .rr_ptr_i (rr_q[req_set]),
        .victim_o (victim_sel)
    );

    // Bus outputs decoded from the current state
    always_comb begin
        bus.proc_ready = 1'b0;
        bus.proc_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_addr   = '0;
        case (state_q)
            IDLE: begin
                if (bus.proc_read && hit) begin
                    bus.proc_ready = 1'b1;
                    bus.proc_rdata = data_q[req_set][hit_way];
                end
            end
            MISS: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = miss_addr_q;
            end
            REFILL: begin
                bus.proc_ready = 1'b1;
                bus.proc_rdata = refill_buf_q;
            end
            default: ;
        endcase
    end

    // Next-state logic for the miss FSM and its capture registers
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        victim_d     = victim_q;
        refill_buf_d = refill_buf_q;
        case (state_q)
            IDLE: begin
                if (bus.proc_read && !hit) begin
                    miss_addr_d = bus.proc_addr;
                    victim_d    = victim_sel;
                    state_d     = MISS;
                end
            end
            MISS: begin
                if (bus.mem_ready) begin
                    refill_buf_d = bus.mem_rdata;
                    state_d      = REFILL;
                end
            end
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and miss-capture registers; reset aborts any outstanding miss
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
        victim_q     <= victim_d;
        refill_buf_q <= refill_buf_d;
    end

    // Line arrays and round-robin pointers; only REFILL writes a line
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < NUM_SET; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < NUM_WAY; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                end
            end
        end else if (state_q == REFILL) begin
            valid_q[miss_set][victim_q] <= 1'b1;
            tag_q[miss_set][victim_q]   <= miss_tag;
            data_q[miss_set][victim_q]  <= refill_buf_q;
            rr_q[miss_set]              <= rr_next;
        end
    end

`ifdef ICACHE_L2_STATS_EN
    logic [31:0] stat_hit_q, stat_miss_q;
    logic        idle_req;

    assign idle_req  = (state_q == IDLE) && bus.proc_read;
    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;

    // Saturating hit/miss counters sampled on IDLE requests
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            if (idle_req && hit && (stat_hit_q != 32'hFFFF_FFFF)) begin
                stat_hit_q <= stat_hit_q + 32'd1;
            end
            if (idle_req && !hit && (stat_miss_q != 32'hFFFF_FFFF)) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_l2_nway.sv
// Self-checking bench for icache_l2_nway (default 28b addr, 128b line,
// 32 sets, 4 ways). A line-level reference model tracks cache contents.
module tb_icache_l2_nway;

    localparam int AW = 28;
    localparam int LW = 128;
    localparam int NS = 32;
    localparam int NW = 4;

    logic clk;
    logic proc_reset;

    icache_l2_nway_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

`ifdef ICACHE_L2_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
`endif

    icache_l2_nway #(
        .ADDR_W  (AW),
        .LINE_W  (LW),
        .NUM_SET (NS),
        .NUM_WAY (NW)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
`ifdef ICACHE_L2_STATS_EN
        ,
        .stat_hit   (stat_hit),
        .stat_miss  (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model: per set, a small table of ways plus a replacement pointer
    bit          m_valid [NS][NW];
    int unsigned m_tag   [NS][NW];
    logic [LW-1:0] m_data [NS][NW];
    int          m_rr    [NS];
    int          m_hits;
    int          m_misses;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = 0;
                m_data[s][w]  = '0;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic m_lookup(input logic [AW-1:0] a, output bit hit, output logic [LW-1:0] line);
        int s;
        int unsigned t;
        s    = int'(a) % NS;
        t    = int'(a) / NS;
        hit  = 0;
        line = '0;
        for (int w = 0; w < NW; w++) begin
            if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin
                hit  = 1;
                line = m_data[s][w];
            end
        end
    endtask

    task automatic m_fill(input logic [AW-1:0] a, input logic [LW-1:0] d);
        int s;
        int v;
        s = int'(a) % NS;
        v = -1;
        for (int w = 0; w < NW; w++) begin
            if (v < 0 && !m_valid[s][w]) v = w;
        end
        if (v < 0) v = m_rr[s];
        m_valid[s][v] = 1;
        m_tag[s][v]   = int'(a) / NS;
        m_data[s][v]  = d;
        m_rr[s]       = (v + 1) % NW;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.mem_ready  = 1'b0;
        proc_reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", LW'(bus.proc_ready), LW'(1'b0));
        chk("rst_memrd", LW'(bus.mem_read), LW'(1'b0));
        chk("rst_memaddr", LW'(bus.mem_addr), '0);
        chk("rst_rdata", bus.proc_rdata, '0);
        proc_reset = 1'b0;
        m_clear();
        @(negedge clk);
    endtask

    // One read transaction; called at a negedge, returns in the following idle cycle
    task automatic do_read(input logic [AW-1:0] a, input int dly, input logic [LW-1:0] d, input bit drop);
        bit            hit;
        logic [LW-1:0] line;
        m_lookup(a, hit, line);
        bus.proc_read = 1'b1;
        bus.proc_addr = a;
        #1;
        if (hit) begin
            m_hits++;
            chk("hit_ready", LW'(bus.proc_ready), LW'(1'b1));
            chk("hit_rdata", bus.proc_rdata, line);
            chk("hit_memrd", LW'(bus.mem_read), LW'(1'b0));
            @(negedge clk);
            bus.proc_read = 1'b0;
        end else begin
            m_misses++;
            chk("miss_ready0", LW'(bus.proc_ready), LW'(1'b0));
            chk("miss_memrd0", LW'(bus.mem_read), LW'(1'b0));
            @(negedge clk);
            if (drop) bus.proc_read = 1'b0;
            for (int i = 0; i < dly; i++) begin
                #1;
                chk("wait_memrd", LW'(bus.mem_read), LW'(1'b1));
                chk("wait_memaddr", LW'(bus.mem_addr), LW'(a));
                chk("wait_ready", LW'(bus.proc_ready), LW'(1'b0));
                @(negedge clk);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = d;
            #1;
            chk("mem_memrd", LW'(bus.mem_read), LW'(1'b1));
            chk("mem_memaddr", LW'(bus.mem_addr), LW'(a));
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = rand_line();
            bus.proc_read = 1'b0;
            #1;
            chk("refill_ready", LW'(bus.proc_ready), LW'(1'b1));
            chk("refill_rdata", bus.proc_rdata, d);
            chk("refill_memrd", LW'(bus.mem_read), LW'(1'b0));
            m_fill(a, d);
            @(negedge clk);
            #1;
            chk("post_ready", LW'(bus.proc_ready), LW'(1'b0));
            chk("post_memrd", LW'(bus.mem_read), LW'(1'b0));
        end
    endtask

    task automatic do_write_only(input logic [AW-1:0] a);
        bus.proc_write = 1'b1;
        bus.proc_wdata = rand_line();
        bus.proc_addr  = a;
        #1;
        chk("wr_ready", LW'(bus.proc_ready), LW'(1'b0));
        chk("wr_memrd", LW'(bus.mem_read), LW'(1'b0));
        @(negedge clk);
        bus.proc_write = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [LW-1:0] a5;
        n_cmp          = 0;
        n_err          = 0;
        a5             = {16{8'hA5}};
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        do_reset();

        // 1 and 2: first miss then 0-cycle hit on the same line
        do_read(28'h0000040, 0, a5, 0);
        do_read(28'h0000040, 0, '0, 0);

        // 3: fill set 0 with four tags, then round-robin eviction of way 0
        do_reset();
        do_read(28'h20, 0, rand_line(), 0);
        do_read(28'h40, 1, rand_line(), 0);
        do_read(28'h60, 0, rand_line(), 0);
        do_read(28'h80, 2, rand_line(), 0);
        do_read(28'hA0, 0, rand_line(), 0);
        do_read(28'h40, 0, '0, 0);
        do_read(28'h20, 0, rand_line(), 0);

        // 4: long memory latency, with and without proc_read held
        do_read(28'h1234567, 10, rand_line(), 0);
        do_read(28'h0765432, 10, rand_line(), 1);
        do_read(28'h0765432, 0, '0, 0);

        // 5: reset while MISS aborts and invalidates
        a = 28'h0000123;
        do_read(a, 0, rand_line(), 0);
        bus.proc_read = 1'b1;
        bus.proc_addr = 28'h0000143;
        #1;
        chk("abort_req_memrd", LW'(bus.mem_read), LW'(1'b0));
        @(negedge clk);
        #1;
        chk("abort_miss_memrd", LW'(bus.mem_read), LW'(1'b1));
        proc_reset    = 1'b1;
        bus.proc_read = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_memrd", LW'(bus.mem_read), LW'(1'b0));
        chk("abort_ready", LW'(bus.proc_ready), LW'(1'b0));
        proc_reset = 1'b0;
        m_clear();
        @(negedge clk);
        do_read(a, 0, rand_line(), 0);
        do_read(28'h0000143, 1, rand_line(), 0);

        // 6: write-only cycles touch nothing; counters track hits/misses
        do_reset();
        do_read(28'h0000001, 0, rand_line(), 0);
        do_read(28'h0000002, 0, rand_line(), 0);
        do_read(28'h0000003, 0, rand_line(), 0);
        for (int i = 0; i < 5; i++) begin
            do_read(28'(1 + (i % 3)), 0, '0, 0);
        end
        do_write_only(28'h0000001);
        do_write_only(28'h0000777);
        do_read(28'h0000777, 0, rand_line(), 0);
        do_read(28'h0000777, 0, '0, 0);
`ifdef ICACHE_L2_STATS_EN
        #1;
        chk("stat_hit", LW'(stat_hit), LW'(m_hits));
        chk("stat_miss", LW'(stat_miss), LW'(m_misses));
        @(negedge clk);
`endif

        // Randomized traffic over a small address pool to mix hits, misses and evictions
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_write_only(28'($urandom_range(0, 255)));
            end else begin
                a = 28'(($urandom_range(0, 7) * NS) + $urandom_range(0, 3));
                do_read(a, $urandom_range(0, 3), rand_line(), $urandom_range(0, 1) == 1);
            end
        end
`ifdef ICACHE_L2_STATS_EN
        #1;
        chk("stat_hit_rand", LW'(stat_hit), LW'(m_hits));
        chk("stat_miss_rand", LW'(stat_miss), LW'(m_misses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
